// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side bundle of the memory stage SRAM controller.
// master = EXE/MEM pipeline side, slave = controller.
interface mem_stage_sram_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output MEM_R_EN,
    output MEM_W_EN,
    output ALU_Res,
    output Val_Rm,
    input  readData,
    input  ready
  );

  modport slave (
    input  MEM_R_EN,
    input  MEM_W_EN,
    input  ALU_Res,
    input  Val_Rm,
    output readData,
    output ready
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: 32-bit LDR/STR as two 16-bit async SRAM accesses.
// Optional MEM_LAST_READ_BUF_EN adds a one-entry last-read buffer.
module mem_stage_sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  output logic [15:0]           SRAM_DQ_OUT,
  input  logic [15:0]           SRAM_DQ_IN,
  output logic                  SRAM_DQ_OE,
  output logic                  SRAM_WE_N
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);
  localparam logic [3:0]  LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [31:0]        r_read_data;

  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic               w_last;
  logic               w_hit;
  logic [31:0]        w_off;
  logic [ADDR_W-2:0]  w_waddr;
  logic               w_unused;

  assign w_req    = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_wr     = bus.MEM_W_EN;
  assign w_rd     = bus.MEM_R_EN & ~bus.MEM_W_EN;
  assign w_last   = (r_cnt == LP_LAST);
  assign w_off    = bus.ALU_Res - LP_BASE;
  assign w_waddr  = w_off[ADDR_W:2];
  assign w_unused = &{1'b0, w_off[31:ADDR_W+1], w_off[1:0]};

`ifdef MEM_LAST_READ_BUF_EN
  logic               r_buf_v;
  logic [ADDR_W-2:0]  r_buf_addr;
  logic [31:0]        r_buf_data;

  assign w_hit = (r_state == S_IDLE) & w_rd & r_buf_v &
                 (r_buf_addr == w_waddr);
`else
  assign w_hit = 1'b0;
`endif

  assign bus.ready    = ((r_state == S_IDLE) & (~w_req | w_hit)) |
                        (r_state == S_DONE);
  assign bus.readData = r_read_data;

  // SRAM pins decode from the current half being accessed
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_OUT = '0;
    SRAM_DQ_OE  = 1'b0;
    SRAM_WE_N   = 1'b1;
    unique case (1'b1)
      (r_state == S_LO): begin
        SRAM_ADDR = {w_waddr, 1'b0};
        if (w_wr) begin
          SRAM_DQ_OUT = bus.Val_Rm[15:0];
          SRAM_DQ_OE  = 1'b1;
          SRAM_WE_N   = 1'b0;
        end
      end
      (r_state == S_HI): begin
        SRAM_ADDR = {w_waddr, 1'b1};
        if (w_wr) begin
          SRAM_DQ_OUT = bus.Val_Rm[31:16];
          SRAM_DQ_OE  = 1'b1;
          SRAM_WE_N   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Access FSM: wait counter per half, load data capture, buffer upkeep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_read_data <= '0;
`ifdef MEM_LAST_READ_BUF_EN
      r_buf_v     <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end
`ifdef MEM_LAST_READ_BUF_EN
          if (w_hit)
            r_read_data <= r_buf_data;
`endif
        end
        S_LO: begin
          if (w_last) begin
            r_state <= S_HI;
            r_cnt   <= '0;
            if (w_rd)
              r_read_data[15:0] <= SRAM_DQ_IN;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HI: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            if (w_rd)
              r_read_data[31:16] <= SRAM_DQ_IN;
`ifdef MEM_LAST_READ_BUF_EN
            if (w_rd) begin
              r_buf_v    <= 1'b1;
              r_buf_addr <= w_waddr;
              r_buf_data <= {SRAM_DQ_IN, r_read_data[15:0]};
            end else if (r_buf_addr == w_waddr) begin
              r_buf_data <= bus.Val_Rm;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl (WAIT_CYCLES=2).
// Define MEM_LAST_READ_BUF_EN to expect buffer hits.
module tb_mem_stage_sram_ctrl;

`ifdef MEM_LAST_READ_BUF_EN
  localparam bit LP_BUF = 1'b1;
`else
  localparam bit LP_BUF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT;
  logic [15:0] SRAM_DQ_IN;
  logic        SRAM_DQ_OE;
  logic        SRAM_WE_N;

  mem_stage_sram_ctrl_if bus ();

  mem_stage_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_OUT(SRAM_DQ_OUT),
    .SRAM_DQ_IN (SRAM_DQ_IN),
    .SRAM_DQ_OE (SRAM_DQ_OE),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  assign SRAM_DQ_IN = mem[SRAM_ADDR[5:0]];
  always @(posedge clk)
    if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ_OUT;

  typedef struct {
    int          id;
    logic        wr;
    logic [17:0] lo_a;
    logic [15:0] lo_d;
    logic [15:0] hi_d;
    int          stall;
    int          nslot;
    int          nwe;
    int          nact;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  int          m_stall, m_lo, m_hi, m_we, m_act;
  bit          pend;
  int          pend_id;
  logic [31:0] pend_rd;
  exp_t        e;

  // Monitor: accumulate bus activity, check on each completion
  always @(negedge clk) begin
    if (!rst) begin
      m_stall = 0; m_lo = 0; m_hi = 0; m_we = 0; m_act = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk($sformatf("readData#%0d", pend_id), bus.readData, pend_rd);
        pend = 1'b0;
      end
      if ((bus.MEM_R_EN | bus.MEM_W_EN) && q.size() > 0) begin
        e = q[0];
        if (!bus.ready) m_stall++;
        if (SRAM_ADDR == e.lo_a && SRAM_WE_N == !e.wr &&
            SRAM_DQ_OE == e.wr && (!e.wr || SRAM_DQ_OUT == e.lo_d))
          m_lo++;
        if (SRAM_ADDR == (e.lo_a | 18'd1) && SRAM_WE_N == !e.wr &&
            SRAM_DQ_OE == e.wr && (!e.wr || SRAM_DQ_OUT == e.hi_d))
          m_hi++;
        if (!SRAM_WE_N) m_we++;
        if (SRAM_ADDR != '0 || SRAM_DQ_OE || !SRAM_WE_N) m_act++;
        if (bus.ready) begin
          void'(q.pop_front());
          chk($sformatf("stall#%0d", e.id), m_stall, e.stall);
          chk($sformatf("lo_cyc#%0d", e.id), m_lo, e.nslot);
          chk($sformatf("hi_cyc#%0d", e.id), m_hi, e.nslot);
          chk($sformatf("we_cyc#%0d", e.id), m_we, e.nwe);
          chk($sformatf("bus_cyc#%0d", e.id), m_act, e.nact);
          pend    = 1'b1;
          pend_id = e.id;
          pend_rd = e.rd;
          m_stall = 0; m_lo = 0; m_hi = 0; m_we = 0; m_act = 0;
        end
      end
    end
  end

  task automatic go_idle();
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.ALU_Res  = '0;
    bus.Val_Rm   = '0;
  endtask

  // Issue one access; expected stall/bus counts are for WAIT_CYCLES=2
  task automatic do_req(int id, logic r, logic w, logic [31:0] a,
                        logic [31:0] d, logic [17:0] lo_a, bit hit,
                        logic [31:0] rd);
    exp_t x;
    bit   done;
    x.id    = id;
    x.wr    = w;
    x.lo_a  = lo_a;
    x.lo_d  = d[15:0];
    x.hi_d  = d[31:16];
    x.stall = hit ? 0 : 5;
    x.nslot = hit ? 0 : 2;
    x.nwe   = w ? 4 : 0;
    x.nact  = hit ? 0 : 4;
    x.rd    = rd;
    q.push_back(x);
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.ALU_Res  = a;
    bus.Val_Rm   = d;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) done = 1'b1;
    end
    if (!done) begin
      n_tot++;
      $display("FAIL timeout#%0d: ready never rose within 50 cycles", id);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    go_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_oe", SRAM_DQ_OE, 0);
    chk("rst_rdata", bus.readData, 0);
    chk("rst_ready", bus.ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_req(1, 0, 1, 32'd1032, 32'hDEADBEEF, 18'd4, 0, 32'h0);
    do_req(2, 1, 0, 32'd1032, 32'h0, 18'd4, 0, 32'hDEADBEEF);
    do_req(3, 1, 1, 32'd1040, 32'hCAFEF00D, 18'd8, 0, 32'hDEADBEEF);
    do_req(4, 1, 0, 32'd1032, 32'h0, 18'd4, LP_BUF, 32'hDEADBEEF);
    do_req(5, 0, 1, 32'd1032, 32'h12345678, 18'd4, 0, 32'hDEADBEEF);
    do_req(6, 1, 0, 32'd1032, 32'h0, 18'd4, LP_BUF, 32'h12345678);
    do_req(7, 0, 1, 32'd1036, 32'hA5A55A5A, 18'd6, 0, 32'h12345678);
    do_req(8, 1, 0, 32'd1036, 32'h0, 18'd6, 0, 32'hA5A55A5A);
    do_req(9, 1, 0, 32'd1041, 32'h0, 18'd8, 0, 32'hCAFEF00D);
    go_idle();
    repeat (2) @(posedge clk);
    #1;

    bus.MEM_W_EN = 1'b1;
    bus.ALU_Res  = 32'd1044;
    bus.Val_Rm   = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    chk("hi_addr", SRAM_ADDR, 11);
    chk("hi_we_n", SRAM_WE_N, 0);
    rst = 1'b0;
    #1;
    chk("abort_we_n", SRAM_WE_N, 1);
    chk("abort_oe", SRAM_DQ_OE, 0);
    chk("abort_addr", SRAM_ADDR, 0);
    chk("abort_rdata", bus.readData, 0);
    go_idle();
    #1;
    chk("abort_ready", bus.ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", bus.ready, 1);

    do_req(10, 1, 0, 32'd1040, 32'h0, 18'd8, 0, 32'hCAFEF00D);
    go_idle();
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_tot++;
      $display("FAIL scoreboard: %0d pending got 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage consumer of the execute stage's memory outputs: ALU result as address, forwarded Rm as store data, MEM_R_EN/MEM_W_EN.
- Performs each 32-bit LDR/STR as two 16-bit accesses on an external asynchronous SRAM, with a fixed number of wait cycles per access.
- Drives `ready` low to freeze the pipeline while an access is in flight.
- Returns load data registered toward the WB stage.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 2, cycles each half-word access occupies the bus (legal range 1..15).
- BASE_ADDR, 1024, byte offset subtracted from ALU_Res before translation.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_R_EN  in  1  load request from the EXE/MEM pipeline register.
- MEM_W_EN  in  1  store request from the EXE/MEM pipeline register.
- ALU_Res  in  32  byte address.
- Val_Rm  in  32  store data.
- readData  out  32  registered load result.
- ready  out  1  high = no access pending or access completing this cycle; pipeline freezes when low.
- SRAM_ADDR  out  ADDR_W  half-word address.
- SRAM_DQ_OUT  out  16  write data to SRAM.
- SRAM_DQ_IN  in  16  read data from SRAM.
- SRAM_DQ_OE  out  1  high = controller drives DQ.
- SRAM_WE_N  out  1  active-low write enable.

Behaviour:
- Request:
  - req = MEM_R_EN | MEM_W_EN.
  - If both are high, the access is a write.
  - Request inputs are held stable by the freeze until ready is seen high.
- Address translation:
  - waddr = (ALU_Res - BASE_ADDR) >> 2, truncated to ADDR_W-1 bits.
  - Low half at {waddr,0}; high half at {waddr,1}.
  - ALU_Res[1:0] is ignored.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: req goes to LO (counter cleared); otherwise stays in IDLE.
  - LO: counter increments each cycle. When counter == WAIT_CYCLES-1: go to HI and clear the counter; on a read, capture SRAM_DQ_IN into readData[15:0].
  - HI: same as LO, but capture into readData[31:16]; exit goes to DONE.
  - DONE: always goes to IDLE.
- ready:
  - Combinational: (state==IDLE & ~req) | (state==DONE).
  - Low during IDLE-with-req, LO and HI.
  - Stall for a request first seen in cycle 0 is exactly 2*WAIT_CYCLES+1 cycles; ready is high in cycle 2*WAIT_CYCLES+1.
- Back-to-back requests: after DONE the FSM returns to IDLE; a new request presented in that IDLE cycle starts a fresh access with no extra bubble.
- SRAM outputs:
  - In LO/HI: SRAM_ADDR = the half address.
  - On a write in LO/HI: SRAM_WE_N=0, SRAM_DQ_OE=1, SRAM_DQ_OUT = Val_Rm[15:0] (LO) or Val_Rm[31:16] (HI).
  - On a read: SRAM_WE_N=1, SRAM_DQ_OE=0.
  - In IDLE/DONE: SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_DQ_OUT=0.
- readData:
  - Holds its value between loads.
  - Stores never modify it.
- Reset values: state=IDLE, counter=0, readData=0, SRAM_WE_N=1, SRAM_DQ_OE=0.
- Reset mid-access: async reset aborts immediately; the partial write may leave one SRAM half updated (acceptable); outputs return to their reset values.

Optional Feature:
- Macro: MEM_LAST_READ_BUF_EN.
- When defined, the controller keeps a one-entry buffer {valid, waddr, data}:
  - Filled on completion of every read.
  - On a write, data is updated if waddr matches.
  - valid cleared on reset.
- Buffer hit: a read in IDLE whose waddr matches a valid entry.
  - ready is high in that same cycle (zero stall); the FSM stays in IDLE.
  - readData is loaded from the buffer on that edge.
  - No SRAM cycle is issued.
- When undefined: no buffer; every read takes the full FSM path.

Test Plan:
- Reset: rst=0 mid-write in HI -> immediately state IDLE, SRAM_WE_N=1, SRAM_DQ_OE=0, readData=0, ready=1 with no request.
- Store, WAIT_CYCLES=2: MEM_W_EN=1, ALU_Res=1024+8, Val_Rm=0xDEADBEEF -> ready low 5 cycles; SRAM_ADDR=4 with DQ_OUT=0xBEEF for 2 cycles, then SRAM_ADDR=5 with DQ_OUT=0xDEAD for 2 cycles; WE_N low during all 4.
- Load of the same address (SRAM model returns stored data) -> ready high in cycle 5; readData=0xDEADBEEF on the following cycle; WE_N stays 1.
- Back-to-back store to 1024+12 then load from 1024+12 -> second access starts in the IDLE cycle directly after DONE; total 10 stall cycles; readData matches the stored value.
- Both MEM_R_EN and MEM_W_EN high -> write cycles issued; readData unchanged.
- With MEM_LAST_READ_BUF_EN: repeat the load of 1024+8 -> ready=1 same cycle, no SRAM_ADDR activity, readData=0xDEADBEEF. Then store 0x12345678 to 1024+8 and load again -> buffer hit returns 0x12345678.
